uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Oversampled UART receive engine on the SoC pin path, directly downstream of the fpioa[0] (uart0_rx) pad. It resynchronises the asynchronous line, qualifies start bits against glitches, and deframes 8N1 bytes with majority-voted mid-bit sampling. Received bytes go through a 4-entry FIFO to the UART register/boot-load logic over a valid/ready handshake. The block reports framing and overrun errors and must stay sane under arbitrary line noise, such as bench toggling of rx every 7 ns.

## Interface
- BAUD_DIV, 434: clocks per bit; legal range 8..65535.
- FIFO_DEPTH, 4: byte FIFO entries; power of two.
- clk  in  1  system clock, the single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_i  in  1  asynchronous serial input; idle high.
- rx_valid_o  out  1  FIFO non-empty.
- rx_data_o  out  8  FIFO head byte; valid only while rx_valid_o=1.
- rx_ready_i  in  1  consumer pop request; a pop occurs when rx_valid_o & rx_ready_i.
- frame_err_o  out  1  one-cycle pulse on a bad stop bit.
- overrun_o  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- busy_o  out  1  state ≠ IDLE.

## Operation
- Input synchroniser: two flops, both reset to 1. Denote its output rxs.
- Bit counter: cnt, width $clog2(BAUD_DIV). HALF = BAUD_DIV/2.
- Majority vote: maj = 2-of-3 of rxs sampled at cnt = HALF-1, HALF and HALF+1.
- States:
  - IDLE: on rxs=0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt=HALF+1, evaluate maj. If maj=1 (false start), go to IDLE. Otherwise continue; at cnt=BAUD_DIV-1, cnt wraps to 0 and the state goes to DATA with bit index 0.
  - DATA: the same per-bit timing applies. maj is shifted in LSB first at cnt=HALF+1. After bit 7 wraps, go to STOP.
  - STOP: evaluate maj at cnt=HALF+1, then act immediately without waiting for the end of the bit.
    - maj=1: push the byte and go to IDLE.
    - maj=0: pulse frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE.
- FIFO:
  - Push and pop in the same cycle when full: both occur, with no overrun.
  - Push when full without a pop: the byte is dropped, overrun_o pulses, and FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. A separate count distinguishes full from empty.
- Noise: a line that is low for fewer than HALF-1 cycles around the start mid-point never produces a byte. No input sequence may lock the FSM; every state returns to IDLE within 11·BAUD_DIV cycles of rxs staying high.

## Timing
- Reset (one clk with rst=1) gives: state IDLE, cnt 0, FIFO empty, sync flops at 1. Output values under reset:
  - rx_valid_o = 0
  - rx_data_o = 0
  - frame_err_o = 0
  - overrun_o = 0
  - busy_o = 0
- Reset mid-frame: the partial byte is lost and reset values apply on the next edge.
- Detection latency: if rx_i falls before edge T, rxs=0 at T+2 and busy_o=1 from T+3.
- Push timing: the stop-bit vote occurs at frame cycle 9·BAUD_DIV+HALF+1. The push is registered on that edge, and rx_valid_o and rx_data_o update on the following cycle.
- frame_err_o and overrun_o are asserted in the same cycle as the would-be push.
- Pop: rx_data_o advances to the next entry (or rx_valid_o drops) on the cycle after the handshake.
- Back-to-back frames: a new start is accepted from the cycle after the stop vote. This tolerates up to ~BAUD_DIV/2 of transmitter clock skew.

## Structure
- Package uart_pkg:
  - state enum: IDLE, START, DATA, STOP, BREAK.
  - localparam DATA_BITS = 8.
- Sub-module uart_rx_fifo: synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, din, pop, dout, empty, full.
- The core instantiates uart_rx_fifo; the FSM, synchroniser, counter and vote logic live in uart_rx_core.

## Test plan
All cases use BAUD_DIV=8.
- Send 0xA5 with rx_ready_i=1:
  - rx_valid_o pulses with rx_data_o=0xA5, 1 cycle after the stop vote.
  - No error pulses.
- Send 0x00 and 0xFF with no idle gap between frames: both bytes are received in order, and frame_err_o stays 0.
- Drive a 2-cycle low glitch on an idle line: busy_o rises and returns to 0 by cycle ~7; no push occurs.
- Send a frame with stop=0 and data 0x3C, held low for 20 cycles:
  - frame_err_o pulses once; no push.
  - busy_o stays 1 until the line goes high.
  - A following 0x11 is received correctly.
- With rx_ready_i=0, send 0x01..0x05:
  - FIFO holds 0x01..0x04.
  - overrun_o pulses once, on the 5th byte.
  - Raising rx_ready_i drains 0x01..0x04 in order.
- Toggle rx_i every 7 ns for 2000 cycles, then send 0x5A with rst pulsed mid-frame once:
  - No lock-up; busy_o returns to 0.
  - After reset, 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO; the occupancy count separates full from empty so pointers can wrap freely.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled 8N1 receiver: two-flop resync, 2-of-3 mid-bit vote, start-bit glitch rejection, byte FIFO.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | timing start bit; false start aborts at the vote point
// DATA  | shifting in data bits LSB first
// STOP  | voting the stop bit; push or flag framing error
// BREAK | line held low after a bad stop, wait for high
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int CW   = $clog2(BAUD_DIV);
   localparam int HALF = BAUD_DIV / 2;
   localparam int BW   = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_HM1  = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(HALF);
   localparam logic [CW-1:0] CNT_VOTE = CW'(HALF + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic [1:0]           sync_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [1:0]           smp_q, smp_d;
   logic                 rxs;
   logic                 maj;
   logic                 push_req;
   logic                 fifo_empty;
   logic                 fifo_full;

   assign rxs = sync_q[1];
   // Third vote sample is the live value at the vote cycle itself.
   assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         smp_q   <= 2'b11;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         smp_q   <= smp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      smp_d       = smp_q;
      push_req    = 1'b0;
      frame_err_o = 1'b0;

      if (cnt_q == CNT_HM1) smp_d[0] = rxs;
      if (cnt_q == CNT_MID) smp_d[1] = rxs;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!rxs) state_d = START;
         end
         START: begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CNT_VOTE && maj) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CNT_VOTE) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
            if (cnt_q == CNT_LAST) begin
               if (bit_q == BIT_LAST) state_d = STOP;
               else                   bit_d   = bit_q + BW'(1);
            end
         end
         STOP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_VOTE) begin
               cnt_d = '0;
               if (maj) begin
                  push_req = 1'b1;
                  state_d  = IDLE;
               end else begin
                  frame_err_o = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy_o     = (state_q != IDLE);
   assign rx_valid_o = ~fifo_empty;
   // Full implies valid, so a raised ready guarantees a pop this cycle.
   assign overrun_o  = push_req & fifo_full & ~rx_ready_i;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .din   (shreg_q),
      .pop   (rx_ready_i),
      .dout  (rx_data_o),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: randomized frames, glitches, framing/overrun cases, noise and reset.
module tb_uart_rx_core;

   localparam int BAUD_DIV   = 8;
   localparam int FIFO_DEPTH = 4;
   // rx drive -> sync (2) -> START (1) -> stop vote cycle -> push edge (+1)
   localparam int PUSH_LAT   = 3 + 9*BAUD_DIV + BAUD_DIV/2 + 1 + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_i = 1'b1;
   logic       rx_ready_i = 1'b1;
   logic       rx_valid_o;
   logic [7:0] rx_data_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pops  = 0;
   int ferr_seen = 0, ferr_exp = 0;
   int ovr_seen  = 0, ovr_exp  = 0;
   int first_valid_cyc = -1;
   int occ = 0;
   bit ignore = 1'b0;
   bit hold_mode = 1'b0;
   bit rand_on = 1'b0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_core #(
      .BAUD_DIV   (BAUD_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx_i),
      .rx_valid_o  (rx_valid_o),
      .rx_data_o   (rx_data_o),
      .rx_ready_i  (rx_ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx_i = 1'b0;
      tick(BAUD_DIV);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         tick(BAUD_DIV);
      end
      rx_i = stop;
      tick(BAUD_DIV);
   endtask

   // Reference: a good frame delivers its byte unless the consumer is stalled with a full FIFO.
   task automatic expect_byte(input logic [7:0] b);
      if (hold_mode && occ == FIFO_DEPTH) begin
         ovr_exp++;
      end else begin
         exp_q.push_back(b);
         if (hold_mode) occ++;
      end
   endtask

   task automatic wait_idle(input int limit, input string name);
      for (int i = 0; i < limit; i++) begin
         if (!busy_o) break;
         tick(1);
      end
      chk(name, busy_o, 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid_o && rx_ready_i) begin
            pops++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (!ignore) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_byte actual=%0h required=none", rx_data_o);
               end else begin
                  chk("rx_byte", rx_data_o, exp_q.pop_front());
               end
            end
         end
         if (!ignore && frame_err_o) ferr_seen++;
         if (!ignore && overrun_o)   ovr_seen++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int pops0;

      tick(2);
      chk("rst_valid", rx_valid_o, 0);
      chk("rst_data", rx_data_o, 0);
      chk("rst_ferr", frame_err_o, 0);
      chk("rst_ovr", overrun_o, 0);
      chk("rst_busy", busy_o, 0);
      rst = 1'b0;
      tick(4);

      // single 0xA5 with latency check
      t0 = cyc;
      expect_byte(8'hA5);
      send_frame(8'hA5, 1'b1);
      tick(3);
      chk("push_latency", first_valid_cyc - t0, PUSH_LAT);
      chk("valid_pulse_done", rx_valid_o, 0);
      chk("a5_no_ferr", ferr_seen, 0);
      chk("a5_no_ovr", ovr_seen, 0);

      // back-to-back 0x00, 0xFF
      expect_byte(8'h00);
      send_frame(8'h00, 1'b1);
      expect_byte(8'hFF);
      send_frame(8'hFF, 1'b1);
      tick(3);
      chk("b2b_drained", exp_q.size(), 0);
      chk("b2b_no_ferr", ferr_seen, 0);

      // 2-cycle glitch
      pops0 = pops;
      rx_i = 1'b0;
      tick(2);
      rx_i = 1'b1;
      tick(2);
      chk("glitch_busy_rise", busy_o, 1);
      wait_idle(10, "glitch_busy_fall");
      tick(4);
      chk("glitch_no_push", pops - pops0, 0);

      // bad stop, line held low 20 cycles
      ferr_exp++;
      send_frame(8'h3C, 1'b0);
      tick(20 - BAUD_DIV);
      chk("break_busy_held", busy_o, 1);
      rx_i = 1'b1;
      wait_idle(5, "break_release");
      chk("break_ferr_once", ferr_seen, ferr_exp);
      tick(4);
      expect_byte(8'h11);
      send_frame(8'h11, 1'b1);
      tick(3);
      chk("after_break_drained", exp_q.size(), 0);

      // stalled consumer, 5 bytes into a 4-deep FIFO
      rx_ready_i = 1'b0;
      hold_mode = 1'b1;
      occ = 0;
      for (int b = 1; b <= 5; b++) begin
         expect_byte(8'(b));
         send_frame(8'(b), 1'b1);
      end
      tick(4);
      chk("ovr_once", ovr_seen, ovr_exp);
      chk("full_valid", rx_valid_o, 1);
      chk("full_head", rx_data_o, 8'h01);
      hold_mode = 1'b0;
      rx_ready_i = 1'b1;
      tick(8);
      chk("drain_done", exp_q.size(), 0);
      chk("drain_valid_low", rx_valid_o, 0);

      // random bytes with a randomly stalling consumer
      rand_on = 1'b1;
      fork
         begin
            for (int n = 0; n < 12; n++) begin
               logic [7:0] rb;
               rb = 8'($urandom_range(0, 255));
               expect_byte(rb);
               send_frame(rb, 1'b1);
               tick($urandom_range(0, 3));
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               tick(1);
               rx_ready_i = 1'($urandom_range(0, 1));
            end
         end
      join
      rx_ready_i = 1'b1;
      tick(6);
      chk("rand_drained", exp_q.size(), 0);

      // line noise, then recovery
      ignore = 1'b1;
      repeat (2857) #7 rx_i = ~rx_i;
      @(posedge clk);
      #1;
      rx_i = 1'b1;
      wait_idle(11*BAUD_DIV + 8, "noise_recover");
      tick(10);
      ignore = 1'b0;

      // reset in the middle of a frame
      rx_i = 1'b0;
      tick(3*BAUD_DIV);
      rst = 1'b1;
      tick(1);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_valid", rx_valid_o, 0);
      chk("midrst_data", rx_data_o, 0);
      rx_i = 1'b1;
      rst = 1'b0;
      tick(20);
      expect_byte(8'h5A);
      send_frame(8'h5A, 1'b1);
      tick(6);
      chk("post_rst_drained", exp_q.size(), 0);
      chk("final_ferr", ferr_seen, ferr_exp);
      chk("final_ovr", ovr_seen, ovr_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
